// File: rtl/ring_output_arbiter_if.sv
// Bundle of the output-channel arbiter signals.
//   master : requesters / link side (drives polarity, requests, flits, ro)
//   slave  : arbiter side (drives grants, so, dout, full flags)
// Signals:
//   polarity            phase select (0: even fills, odd drains; 1: odd fills, even drains)
//   req_even/req_odd    per-input requests per VC
//   din_even/din_odd    per-input flits per VC, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   grant_even/odd      one-hot combinational grants
//   ro                  downstream ready
//   so                  registered send strobe
//   dout                registered flit to link
//   full_even/full_odd  per-VC buffer valid
interface ring_output_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REQ    = 3
);
  logic                          polarity;
  logic [NUM_REQ-1:0]            req_even;
  logic [NUM_REQ-1:0]            req_odd;
  logic [NUM_REQ*DATA_WIDTH-1:0] din_even;
  logic [NUM_REQ*DATA_WIDTH-1:0] din_odd;
  logic [NUM_REQ-1:0]            grant_even;
  logic [NUM_REQ-1:0]            grant_odd;
  logic                          ro;
  logic                          so;
  logic [DATA_WIDTH-1:0]         dout;
  logic                          full_even;
  logic                          full_odd;

  modport master (
    output polarity, req_even, req_odd, din_even, din_odd, ro,
    input  grant_even, grant_odd, so, dout, full_even, full_odd
  );

  modport slave (
    input  polarity, req_even, req_odd, din_even, din_odd, ro,
    output grant_even, grant_odd, so, dout, full_even, full_odd
  );
endinterface

// File: rtl/ring_output_arbiter.sv
// Output-port controller for one router output channel. Each VC has a one-entry
// buffer. Polarity picks the phase: the VC equal to polarity fills from the
// arbitrated requesters, the other VC drains to the link when ro is high.
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous active-high reset (discards buffered flits, grants forced 0)
//   bus  ring_output_arbiter_if.slave (requests/flits in, grants/so/dout/full out)
// Configuration macro:
//   OUTARB_FIXED_PRIO_EN  defined: lowest-index requester always wins, no rr state.
//                         undefined (default): independent round-robin per VC.
module ring_output_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REQ    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  ring_output_arbiter_if.slave  bus
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                  valid_even_q, valid_even_d;
  logic                  valid_odd_q,  valid_odd_d;
  logic [DATA_WIDTH-1:0] buf_even_q,   buf_even_d;
  logic [DATA_WIDTH-1:0] buf_odd_q,    buf_odd_d;
  logic                  so_q,         so_d;
  logic [DATA_WIDTH-1:0] dout_q,       dout_d;
  logic [PW-1:0]         rr_even_q;
  logic [PW-1:0]         rr_odd_q;
  logic [NUM_REQ-1:0]    grant_even;
  logic [NUM_REQ-1:0]    grant_odd;

  // Lowest-set-bit one-hot of v.
  function automatic logic [NUM_REQ-1:0] first_one(input logic [NUM_REQ-1:0] v);
    logic [NUM_REQ-1:0] g;
    logic               found;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && v[i]) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  // Round-robin pick: first requester at or above start, else wrap to lowest.
  function automatic logic [NUM_REQ-1:0] pick(input logic [NUM_REQ-1:0] req,
                                              input logic [PW-1:0]      start);
    logic [NUM_REQ-1:0] upper;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      upper[i] = req[i] && (i >= 32'(start));
    return (upper != '0) ? first_one(upper) : first_one(req);
  endfunction

  // Pointer after a grant: one past the granted index, wrapping.
  function automatic logic [PW-1:0] next_ptr(input logic [NUM_REQ-1:0] g);
    logic [PW-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (g[i]) p = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
    return p;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sel_din(input logic [NUM_REQ*DATA_WIDTH-1:0] din,
                                                    input logic [NUM_REQ-1:0]            g);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (g[i]) d = din[i*DATA_WIDTH +: DATA_WIDTH];
    return d;
  endfunction

  always_comb begin
    grant_even = '0;
    grant_odd  = '0;
    if (!rst) begin
      if (!bus.polarity) begin
        if (!valid_even_q) grant_even = pick(bus.req_even, rr_even_q);
      end else begin
        if (!valid_odd_q)  grant_odd  = pick(bus.req_odd, rr_odd_q);
      end
    end
  end

  always_comb begin
    valid_even_d = valid_even_q;
    valid_odd_d  = valid_odd_q;
    buf_even_d   = buf_even_q;
    buf_odd_d    = buf_odd_q;
    dout_d       = dout_q;
    so_d         = 1'b0;

    if (grant_even != '0) begin
      buf_even_d   = sel_din(bus.din_even, grant_even);
      valid_even_d = 1'b1;
    end
    if (grant_odd != '0) begin
      buf_odd_d   = sel_din(bus.din_odd, grant_odd);
      valid_odd_d = 1'b1;
    end

    // Drain the VC opposite the fill phase; it never collides with the fill above.
    if (bus.polarity) begin
      if (valid_even_q && bus.ro) begin
        dout_d       = buf_even_q;
        so_d         = 1'b1;
        valid_even_d = 1'b0;
      end
    end else begin
      if (valid_odd_q && bus.ro) begin
        dout_d      = buf_odd_q;
        so_d        = 1'b1;
        valid_odd_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_even_q <= 1'b0;
      valid_odd_q  <= 1'b0;
      buf_even_q   <= '0;
      buf_odd_q    <= '0;
      so_q         <= 1'b0;
      dout_q       <= '0;
    end else begin
      valid_even_q <= valid_even_d;
      valid_odd_q  <= valid_odd_d;
      buf_even_q   <= buf_even_d;
      buf_odd_q    <= buf_odd_d;
      so_q         <= so_d;
      dout_q       <= dout_d;
    end
  end

`ifdef OUTARB_FIXED_PRIO_EN
  // Search always starts at index 0, so pick() degenerates to lowest-index wins.
  assign rr_even_q = '0;
  assign rr_odd_q  = '0;
`else
  logic [PW-1:0] rr_even_d;
  logic [PW-1:0] rr_odd_d;

  always_comb begin
    rr_even_d = rr_even_q;
    rr_odd_d  = rr_odd_q;
    if (grant_even != '0) rr_even_d = next_ptr(grant_even);
    if (grant_odd  != '0) rr_odd_d  = next_ptr(grant_odd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_even_q <= '0;
      rr_odd_q  <= '0;
    end else begin
      rr_even_q <= rr_even_d;
      rr_odd_q  <= rr_odd_d;
    end
  end
`endif

  assign bus.grant_even = grant_even;
  assign bus.grant_odd  = grant_odd;
  assign bus.so         = so_q;
  assign bus.dout       = dout_q;
  assign bus.full_even  = valid_even_q;
  assign bus.full_odd   = valid_odd_q;

endmodule

// File: tb/tb_ring_output_arbiter.sv
// Self-checking bench for ring_output_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_ring_output_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned N  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ring_output_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus ();

  ring_output_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: per-VC one-entry buffer, rr start index, link registers.
  bit                m_valid [2];
  logic [DW-1:0]     m_buf   [2];
  int unsigned       m_rr    [2];
  logic              m_so;
  logic [DW-1:0]     m_dout;

  function automatic logic [N-1:0] model_grant(input int unsigned v);
    logic [N-1:0] req;
    int unsigned  start;
    int unsigned  idx;
    logic [N-1:0] one;
    if (rst || v != 32'(bus.polarity) || m_valid[v]) return '0;
    req = (v == 1) ? bus.req_odd : bus.req_even;
`ifdef OUTARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_rr[v];
`endif
    one = 1;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (req[idx]) return one << idx;
    end
    return '0;
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic tick();
    logic [N-1:0] g;
    int unsigned  f;
    int unsigned  d;
    logic [N*DW-1:0] din;
    if (rst) begin
      m_valid[0] = 0; m_valid[1] = 0;
      m_rr[0] = 0;    m_rr[1] = 0;
      m_so = 0;       m_dout = '0;
    end else begin
      f = 32'(bus.polarity);
      d = 1 - f;
      g = model_grant(f);
      din = (f == 1) ? bus.din_odd : bus.din_even;
      if (m_valid[d] && bus.ro) begin
        m_dout = m_buf[d];
        m_so = 1;
        m_valid[d] = 0;
      end else begin
        m_so = 0;
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (g[i]) begin
          m_buf[f]   = din[i*DW +: DW];
          m_valid[f] = 1;
          m_rr[f]    = (i + 1) % N;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.polarity = 1'b0;
    bus.req_even = '0;
    bus.req_odd  = '0;
    bus.din_even = '0;
    bus.din_odd  = '0;
    bus.ro       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.req_even = 3'b111;
    #1;
    vectors++;
    if (bus.grant_even !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_grant: got %b expected 000", bus.grant_even);
    end
    tick();
    rst = 1'b0;
    bus.req_even = '0;
    vectors++;
    if (bus.full_even !== 1'b0 || bus.full_odd !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_full: got %b%b expected 00", bus.full_even, bus.full_odd);
    end
    vectors++;
    if (bus.so !== 1'b0 || bus.dout !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_link: got so=%b dout=%h expected so=0 dout=0", bus.so, bus.dout);
    end
  endtask

  task automatic test_basic();
    do_reset();
    bus.polarity = 1'b0;
    bus.req_even = 3'b001;
    bus.din_even[0 +: DW] = 64'hA;
    #1;
    vectors++;
    if (bus.grant_even !== 3'b001) begin
      miscompares++;
      $display("FAIL basic_grant: got %b expected 001", bus.grant_even);
    end
    tick();
    bus.req_even = '0;
    bus.polarity = 1'b1;
    bus.ro = 1'b1;
    vectors++;
    if (bus.full_even !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_full: got %b expected 1", bus.full_even);
    end
    tick();
    vectors++;
    if (bus.so !== 1'b1 || bus.dout !== 64'hA || bus.full_even !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_send: got so=%b dout=%h full=%b expected 1 a 0",
               bus.so, bus.dout, bus.full_even);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g [3];
`ifdef OUTARB_FIXED_PRIO_EN
    exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001;
`else
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
`endif
    do_reset();
    for (int unsigned i = 0; i < N; i++) bus.din_even[i*DW +: DW] = 64'h100 + 64'(i);
    bus.ro = 1'b1;
    for (int unsigned r = 0; r < 3; r++) begin
      bus.polarity = 1'b0;
      bus.req_even = 3'b111;
      #1;
      vectors++;
      if (bus.grant_even !== exp_g[r]) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got %b expected %b", r, bus.grant_even, exp_g[r]);
      end
      tick();
      bus.polarity = 1'b1;
      bus.req_even = '0;
      tick();
      vectors++;
      if (bus.so !== 1'b1 || bus.dout !== m_dout) begin
        miscompares++;
        $display("FAIL rr_send%0d: got so=%b dout=%h expected so=1 dout=%h", r, bus.so, bus.dout, m_dout);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.ro = 1'b0;
    bus.polarity = 1'b0;
    bus.req_even = 3'b001;
    bus.din_even[0 +: DW] = 64'h5;
    bus.din_even[1*DW +: DW] = 64'h6;
    tick();
    bus.req_even = '0;
    bus.polarity = 1'b1;
    tick();
    vectors++;
    if (bus.full_even !== 1'b1 || bus.so !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_hold: got full=%b so=%b expected full=1 so=0", bus.full_even, bus.so);
    end
    bus.polarity = 1'b0;
    bus.req_even = 3'b010;
    #1;
    vectors++;
    if (bus.grant_even !== 3'b000) begin
      miscompares++;
      $display("FAIL bp_blocked: got %b expected 000", bus.grant_even);
    end
    tick();
    bus.polarity = 1'b1;
    bus.req_even = '0;
    bus.ro = 1'b1;
    tick();
    vectors++;
    if (bus.so !== 1'b1 || bus.dout !== 64'h5) begin
      miscompares++;
      $display("FAIL bp_release: got so=%b dout=%h expected so=1 dout=5", bus.so, bus.dout);
    end
    bus.polarity = 1'b0;
    bus.req_even = 3'b010;
    #1;
    vectors++;
    if (bus.grant_even !== 3'b010) begin
      miscompares++;
      $display("FAIL bp_regrant: got %b expected 010", bus.grant_even);
    end
    tick();
    bus.req_even = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.polarity = 1'b1;
    bus.req_odd = 3'b001;
    bus.din_odd[0 +: DW] = 64'hBEEF_0001;
    bus.din_even[2*DW +: DW] = 64'hCAFE_0002;
    tick();
    bus.req_odd = '0;
    bus.polarity = 1'b0;
    bus.ro = 1'b1;
    bus.req_even = 3'b100;
    #1;
    vectors++;
    if (bus.grant_even !== 3'b100 || bus.grant_odd !== 3'b000) begin
      miscompares++;
      $display("FAIL sim_grant: got even=%b odd=%b expected 100 000", bus.grant_even, bus.grant_odd);
    end
    tick();
    bus.req_even = '0;
    vectors++;
    if (bus.so !== 1'b1 || bus.dout !== 64'hBEEF_0001 ||
        bus.full_odd !== 1'b0 || bus.full_even !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_update: got so=%b dout=%h fo=%b fe=%b expected 1 beef0001 0 1",
               bus.so, bus.dout, bus.full_odd, bus.full_even);
    end
    bus.polarity = 1'b1;
    tick();
    vectors++;
    if (bus.so !== 1'b1 || bus.dout !== 64'hCAFE_0002) begin
      miscompares++;
      $display("FAIL sim_drain: got so=%b dout=%h expected 1 cafe0002", bus.so, bus.dout);
    end
  endtask

  task automatic test_phase_mask();
    do_reset();
    bus.polarity = 1'b1;
    bus.req_even = 3'b111;
    bus.req_odd  = 3'b000;
    bus.ro = 1'b1;
    #1;
    vectors++;
    if (bus.grant_even !== 3'b000 || bus.grant_odd !== 3'b000) begin
      miscompares++;
      $display("FAIL mask_grant: got even=%b odd=%b expected 000 000", bus.grant_even, bus.grant_odd);
    end
    tick();
    vectors++;
    if (bus.full_even !== 1'b0 || bus.full_odd !== 1'b0 || bus.so !== 1'b0) begin
      miscompares++;
      $display("FAIL mask_state: got fe=%b fo=%b so=%b expected 0 0 0",
               bus.full_even, bus.full_odd, bus.so);
    end
    bus.req_even = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Even fill from index 1 leaves the even pointer at 2; then a drain makes dout nonzero.
    bus.din_even[1*DW +: DW] = 64'h77;
    bus.din_odd[1*DW +: DW]  = 64'h88;
    bus.polarity = 1'b0; bus.req_even = 3'b010; bus.ro = 1'b0;
    tick();
    bus.req_even = '0; bus.polarity = 1'b1; bus.ro = 1'b1;
    tick();
    bus.ro = 1'b0; bus.req_odd = 3'b010;
    tick();
    bus.req_odd = '0; bus.polarity = 1'b0; bus.req_even = 3'b010;
    tick();
    bus.req_even = '0;
    vectors++;
    if (bus.full_even !== 1'b1 || bus.full_odd !== 1'b1 || bus.dout !== 64'h77) begin
      miscompares++;
      $display("FAIL mid_prefill: got fe=%b fo=%b dout=%h expected 1 1 77",
               bus.full_even, bus.full_odd, bus.dout);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.full_even !== 1'b0 || bus.full_odd !== 1'b0 || bus.so !== 1'b0 || bus.dout !== 64'h0) begin
      miscompares++;
      $display("FAIL mid_reset: got fe=%b fo=%b so=%b dout=%h expected 0 0 0 0",
               bus.full_even, bus.full_odd, bus.so, bus.dout);
    end
    bus.polarity = 1'b0;
    bus.req_even = 3'b111;
    #1;
    vectors++;
    if (bus.grant_even !== 3'b001) begin
      miscompares++;
      $display("FAIL mid_first_grant: got %b expected 001", bus.grant_even);
    end
    tick();
    bus.req_even = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    logic [N-1:0] og;
    do_reset();
    for (int unsigned c = 0; c < 400; c++) begin
      rst          = ($urandom_range(0, 39) == 0);
      bus.polarity = 1'($urandom);
      bus.req_even = N'($urandom);
      bus.req_odd  = N'($urandom);
      bus.ro       = ($urandom_range(0, 3) != 0);
      for (int unsigned i = 0; i < N; i++) begin
        bus.din_even[i*DW +: DW] = {$urandom, $urandom};
        bus.din_odd[i*DW +: DW]  = {$urandom, $urandom};
      end
      #1;
      eg = model_grant(0);
      og = model_grant(1);
      vectors++;
      if (bus.grant_even !== eg || bus.grant_odd !== og) begin
        miscompares++;
        $display("FAIL rand_grant c%0d: got even=%b odd=%b expected even=%b odd=%b",
                 c, bus.grant_even, bus.grant_odd, eg, og);
      end
      tick();
      vectors++;
      if (bus.so !== m_so || bus.dout !== m_dout ||
          bus.full_even !== m_valid[0] || bus.full_odd !== m_valid[1]) begin
        miscompares++;
        $display("FAIL rand_regs c%0d: got so=%b dout=%h fe=%b fo=%b expected so=%b dout=%h fe=%b fo=%b",
                 c, bus.so, bus.dout, bus.full_even, bus.full_odd,
                 m_so, m_dout, m_valid[0], m_valid[1]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_valid[0] = 0; m_valid[1] = 0;
    m_rr[0] = 0;    m_rr[1] = 0;
    m_buf[0] = '0;  m_buf[1] = '0;
    m_so = 0;       m_dout = '0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_simultaneous();
    test_phase_mask();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
